tt_sweep_gen: RTL and testbench

Synthesisable, parametrised successor to our hand-written exhaustive input-sweep benches for small combinational blocks. It drives an N-bit input vector through 0..LAST, holding each value for HOLD clocks. On the last hold cycle it samples the DUT output and compares it against an expected truth table. Results are reported as a pass flag, a saturating error count and the first failing vector. It sits beside a combinational DUT, on-chip or in a bench, and replaces per-block hand-coded stimulus lists.

---
 rtl/tt_sweep_pkg.sv | 22 ++
 rtl/tt_sweep_gen_if.sv | 29 ++
 rtl/tt_sweep_gen_hold_timer.sv | 29 ++
 rtl/tt_sweep_gen.sv | 131 +++++++++++++
 tb/tb_tt_sweep_gen.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_sweep_pkg.sv
// Shared types and helpers for the exhaustive input-sweep generator.
package tt_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Width of a counter that must reach hold-1; never narrower than one bit.
  function automatic int hold_w(input int hold);
    return (hold <= 2) ? 1 : $clog2(hold);
  endfunction

  // Increment that sticks at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [32:0] max_val;
    max_val = (33'd1 << w) - 33'd1;
    return ({1'b0, v} >= max_val) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/tt_sweep_gen_if.sv
// Stimulus/result bundle between a sweep controller and the sweep generator.
interface tt_sweep_gen_if #(
  parameter int N    = 4,
  parameter int ERRW = 8
);
  logic            start;
  logic            abort;
  logic            loop;
  logic            f_in;
  logic [N-1:0]    vec;
  logic            sample;
  logic            busy;
  logic            done;
  logic            pass;
  logic [ERRW-1:0] err_cnt;
  logic [N-1:0]    first_err_vec;
  logic            first_err_vld;
  logic [7:0]      sweep_cnt;

  modport master (
    output start, abort, loop, f_in,
    input  vec, sample, busy, done, pass, err_cnt, first_err_vec, first_err_vld, sweep_cnt
  );

  modport slave (
    input  start, abort, loop, f_in,
    output vec, sample, busy, done, pass, err_cnt, first_err_vec, first_err_vld, sweep_cnt
  );
endinterface

// File: rtl/tt_sweep_gen_hold_timer.sv
// Per-vector hold counter; tc marks the last cycle a vector is held.
module hold_timer #(
  parameter int HOLD = 200,
  parameter int W    = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic         tc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_reg;

  assign count = count_reg;
  assign tc    = en && (count_reg == W'(HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clr) begin
      count_reg <= '0;
    end else if (en) begin
      count_reg <= tc ? '0 : count_reg + W'(1);
    end
  end

endmodule

// File: rtl/tt_sweep_gen.sv
// Drives 0..LAST into a combinational block, checks each value against EXPECT
// on its final hold cycle and keeps pass/error/first-failure results.
module tt_sweep_gen
  import tt_sweep_pkg::*;
#(
  parameter int             N      = 4,
  parameter int             HOLD   = 200,
  parameter int             LAST   = 12,
  parameter logic [2**N-1:0] EXPECT = '0,
  parameter int             ERRW   = 8
) (
  input logic clk,
  input logic rst,
  tt_sweep_gen_if.slave bus
);

  localparam int HW = hold_w(HOLD);

  if (LAST > 2**N - 1 || HOLD < 1) begin : g_param_check
    $error("tt_sweep_gen: LAST must fit in N bits and HOLD must be >= 1");
  end

  state_t          state_reg, state_next;
  logic [N-1:0]    vec_reg, vec_next;
  logic [ERRW-1:0] err_cnt_reg, err_cnt_next;
  logic [N-1:0]    first_err_vec_reg, first_err_vec_next;
  logic            first_err_vld_reg, first_err_vld_next;
  logic [7:0]      sweep_cnt_reg, sweep_cnt_next;

  logic            tc;
  logic            start_ok;
  logic [HW-1:0]   hold_count;

  // A fresh start or an abort restarts the hold phase from zero.
  assign start_ok = bus.start && !bus.abort &&
                    (state_reg == ST_IDLE || state_reg == ST_DONE);

  hold_timer #(
    .HOLD (HOLD),
    .W    (HW)
  ) u_hold (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.abort || start_ok),
    .en    (state_reg == ST_DRIVE && !bus.abort),
    .tc    (tc),
    .count (hold_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg         <= ST_IDLE;
      vec_reg           <= '0;
      err_cnt_reg       <= '0;
      first_err_vec_reg <= '0;
      first_err_vld_reg <= 1'b0;
      sweep_cnt_reg     <= '0;
    end else begin
      state_reg         <= state_next;
      vec_reg           <= vec_next;
      err_cnt_reg       <= err_cnt_next;
      first_err_vec_reg <= first_err_vec_next;
      first_err_vld_reg <= first_err_vld_next;
      sweep_cnt_reg     <= sweep_cnt_next;
    end
  end

  always_comb begin
    state_next         = state_reg;
    vec_next           = vec_reg;
    err_cnt_next       = err_cnt_reg;
    first_err_vec_next = first_err_vec_reg;
    first_err_vld_next = first_err_vld_reg;
    sweep_cnt_next     = sweep_cnt_reg;

    if (bus.abort) begin
      state_next = ST_IDLE;
      vec_next   = '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_DONE: begin
          if (bus.start) begin
            state_next         = ST_DRIVE;
            vec_next           = '0;
            err_cnt_next       = '0;
            first_err_vec_next = '0;
            first_err_vld_next = 1'b0;
            sweep_cnt_next     = '0;
          end
        end
        ST_DRIVE: begin
          if (tc) begin
            // The final vector's result is folded in on the same edge that ends the sweep.
            if (bus.f_in != EXPECT[vec_reg]) begin
              err_cnt_next = ERRW'(sat_inc(32'(err_cnt_reg), ERRW));
              if (!first_err_vld_reg) begin
                first_err_vec_next = vec_reg;
                first_err_vld_next = 1'b1;
              end
            end
            if (vec_reg == N'(LAST)) begin
              sweep_cnt_next = sweep_cnt_reg + 8'd1;
              if (bus.loop) begin
                vec_next = '0;
              end else begin
                state_next = ST_DONE;
              end
            end else begin
              vec_next = vec_reg + N'(1);
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
          vec_next   = '0;
        end
      endcase
    end
  end

  assign bus.vec           = vec_reg;
  assign bus.sample        = tc;
  assign bus.busy          = (state_reg == ST_DRIVE);
  assign bus.done          = (state_reg == ST_DONE);
  assign bus.pass          = (state_reg == ST_DONE) && (err_cnt_reg == '0);
  assign bus.err_cnt       = err_cnt_reg;
  assign bus.first_err_vec = first_err_vec_reg;
  assign bus.first_err_vld = first_err_vld_reg;
  assign bus.sweep_cnt     = sweep_cnt_reg;

endmodule

// File: tb/tb_tt_sweep_gen.sv
// Randomised sweeps against an arithmetic model of the sweep timeline and results.
module tb_tt_sweep_gen;
  localparam logic [15:0] EXP  = 16'h1A5C;
  localparam int          LAST = 12;
  localparam int          H    = 4;
  localparam int          PER  = (LAST + 1) * H;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [15:0] fault_mask = '0;
  logic        sat_f      = 1'b1;

  tt_sweep_gen_if #(.N(4), .ERRW(8)) bus_main ();
  tt_sweep_gen_if #(.N(4), .ERRW(2)) bus_sat ();
  tt_sweep_gen_if #(.N(4), .ERRW(8)) bus_h1 ();

  // Each DUT's f_in behaves like a combinational block under test.
  assign bus_main.f_in = EXP[bus_main.vec] ^ fault_mask[bus_main.vec];
  assign bus_sat.f_in  = sat_f;
  assign bus_h1.f_in   = EXP[bus_h1.vec];

  tt_sweep_gen #(.N(4), .HOLD(H), .LAST(LAST), .EXPECT(EXP), .ERRW(8)) u_main (
    .clk (clk), .rst (rst), .bus (bus_main));
  tt_sweep_gen #(.N(4), .HOLD(H), .LAST(LAST), .EXPECT(EXP), .ERRW(2)) u_sat (
    .clk (clk), .rst (rst), .bus (bus_sat));
  tt_sweep_gen #(.N(4), .HOLD(1), .LAST(LAST), .EXPECT(EXP), .ERRW(8)) u_h1 (
    .clk (clk), .rst (rst), .bus (bus_h1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, want %0h (t=%0t)", tag, obs, exp_v, $time);
    end
  endtask

  task automatic chk_main_idle(input string tag, input int e_err, input int e_fvld,
                               input int e_fvec, input int e_sw);
    chk({tag, ".busy"}, bus_main.busy, 0);
    chk({tag, ".done"}, bus_main.done, 0);
    chk({tag, ".vec"}, bus_main.vec, 0);
    chk({tag, ".sample"}, bus_main.sample, 0);
    chk({tag, ".pass"}, bus_main.pass, 0);
    chk({tag, ".err"}, bus_main.err_cnt, e_err);
    chk({tag, ".fvld"}, bus_main.first_err_vld, e_fvld);
    chk({tag, ".fvec"}, bus_main.first_err_vec, e_fvec);
    chk({tag, ".sweeps"}, bus_main.sweep_cnt, e_sw);
  endtask

  // Full run on the main DUT; poke_t >= 0 re-asserts start mid-sweep (must be ignored).
  task automatic run_main(input logic [15:0] mask, input int nsweeps, input int poke_t);
    int pc, first, errs, total;
    pc = 0; first = -1;
    for (int k = 0; k <= LAST; k++) begin
      if (mask[k]) begin
        pc++;
        if (first < 0) first = k;
      end
    end
    errs  = (pc * nsweeps > 255) ? 255 : pc * nsweeps;
    total = PER * nsweeps;
    fault_mask = mask;
    @(negedge clk);
    bus_main.start = 1'b1;
    bus_main.loop  = (nsweeps > 1);
    for (int t = 0; t < total; t++) begin
      @(negedge clk);
      bus_main.start = (t == poke_t);
      bus_main.loop  = ((t / PER) < nsweeps - 1);
      chk("run.busy", bus_main.busy, 1);
      chk("run.done", bus_main.done, 0);
      chk("run.vec", bus_main.vec, (t / H) % (LAST + 1));
      chk("run.sample", bus_main.sample, ((t % H) == H - 1) ? 1 : 0);
    end
    @(negedge clk);
    bus_main.start = 1'b0;
    bus_main.loop  = 1'b0;
    chk("end.done", bus_main.done, 1);
    chk("end.busy", bus_main.busy, 0);
    chk("end.vec", bus_main.vec, LAST);
    chk("end.sample", bus_main.sample, 0);
    chk("end.err", bus_main.err_cnt, errs);
    chk("end.pass", bus_main.pass, (errs == 0) ? 1 : 0);
    chk("end.fvld", bus_main.first_err_vld, (first >= 0) ? 1 : 0);
    chk("end.fvec", bus_main.first_err_vec, (first >= 0) ? first : 0);
    chk("end.sweeps", bus_main.sweep_cnt, nsweeps);
    $display("[TB] run mask=%04h sweeps=%0d poke=%0d -> err=%0d first=%0d", mask, nsweeps,
             poke_t, bus_main.err_cnt, bus_main.first_err_vec);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int sat_bad;
    logic [15:0] m;
    bus_main.start = 0; bus_main.abort = 0; bus_main.loop = 0;
    bus_sat.start  = 0; bus_sat.abort  = 0; bus_sat.loop  = 0;
    bus_h1.start   = 0; bus_h1.abort   = 0; bus_h1.loop   = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk_main_idle("reset", 0, 0, 0, 0);
    chk("reset.sat_err", bus_sat.err_cnt, 0);
    chk("reset.h1_sample", bus_h1.sample, 0);

    // Clean sweep, then single and double faults, then a looping run.
    run_main(16'h0000, 1, -1);
    run_main(16'h0020, 1, -1);
    run_main(16'h0220, 1, -1);
    run_main(16'h0220, 3, -1);
    run_main(16'h0000, 1, 10);

    // Abort mid-hold at vec 7 together with start: abort wins, counters kept.
    fault_mask = 16'h0020;
    @(negedge clk);
    bus_main.start = 1'b1;
    for (int t = 0; t < 7 * H + 2; t++) begin
      @(negedge clk);
      bus_main.start = 1'b0;
    end
    chk("abort.pre_vec", bus_main.vec, 7);
    bus_main.abort = 1'b1;
    bus_main.start = 1'b1;
    @(negedge clk);
    bus_main.abort = 1'b0;
    bus_main.start = 1'b0;
    chk_main_idle("abort", 1, 1, 5, 0);
    @(negedge clk);
    chk("abort.stay_idle", bus_main.busy, 0);
    $display("[TB] abort at vec 7 -> err=%0d busy=%0d", bus_main.err_cnt, bus_main.busy);
    run_main(16'h0000, 1, -1);

    // Abort from DONE keeps counters but drops done/pass.
    run_main(16'h0200, 1, -1);
    bus_main.abort = 1'b1;
    @(negedge clk);
    bus_main.abort = 1'b0;
    chk_main_idle("abort_done", 1, 1, 9, 1);

    // Randomised fault masks, loop counts and ignored mid-sweep starts.
    for (int i = 0; i < 6; i++) begin
      m = 16'($urandom) & 16'h1FFF;
      if ($urandom_range(0, 2) == 0) m = '0;
      run_main(m, int'($urandom_range(1, 3)),
               ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 40)) : -1);
    end

    // Saturating 2-bit counter with f_in stuck high.
    sat_f = 1'b1;
    @(negedge clk);
    bus_sat.start = 1'b1;
    for (int t = 0; t < PER; t++) begin
      @(negedge clk);
      bus_sat.start = 1'b0;
      sat_bad = 0;
      for (int k = 0; k < t / H; k++) if (EXP[k] != sat_f) sat_bad++;
      chk("sat.err_run", bus_sat.err_cnt, (sat_bad > 3) ? 3 : sat_bad);
    end
    @(negedge clk);
    chk("sat.done", bus_sat.done, 1);
    chk("sat.err", bus_sat.err_cnt, 3);
    chk("sat.fvld", bus_sat.first_err_vld, 1);
    chk("sat.fvec", bus_sat.first_err_vec, 0);
    chk("sat.pass", bus_sat.pass, 0);
    $display("[TB] sat run -> err=%0d first=%0d", bus_sat.err_cnt, bus_sat.first_err_vec);

    // HOLD=1: sample high on every drive cycle.
    @(negedge clk);
    bus_h1.start = 1'b1;
    for (int t = 0; t <= LAST; t++) begin
      @(negedge clk);
      bus_h1.start = 1'b0;
      chk("h1.sample", bus_h1.sample, 1);
      chk("h1.vec", bus_h1.vec, t);
    end
    @(negedge clk);
    chk("h1.done", bus_h1.done, 1);
    chk("h1.pass", bus_h1.pass, 1);
    chk("h1.sample_off", bus_h1.sample, 0);
    $display("[TB] hold1 run -> pass=%0d", bus_h1.pass);

    // Asynchronous reset between edges while vec 3 is being sampled.
    fault_mask = 16'h0002;
    @(negedge clk);
    bus_main.start = 1'b1;
    for (int t = 0; t < 3 * H + 4; t++) begin
      @(negedge clk);
      bus_main.start = 1'b0;
    end
    chk("rst.pre_sample", bus_main.sample, 1);
    chk("rst.pre_err", bus_main.err_cnt, 1);
    #2 rst = 1'b1;
    #1;
    chk_main_idle("async_rst", 0, 0, 0, 0);
    chk("async_rst.h1_done", bus_h1.done, 0);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("post_rst.busy", bus_main.busy, 0);
    $display("[TB] async reset at vec 3 -> busy=%0d err=%0d", bus_main.busy, bus_main.err_cnt);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
